fir_out_stream: RTL

//  Parametrised output buffer between the FIR datapath and the output interface.

---
 rtl/fir_out_stream_pkg.sv | 23 ++
 rtl/fir_out_stream_if.sv | 24 ++
 rtl/fir_out_stream_fifo.sv | 78 +++++++
 rtl/fir_out_stream.sv | 115 +++++++++++
 4 files changed

// File: rtl/fir_out_stream_pkg.sv
// Shared types and defaults for the FIR output stage: sample entry layout,
// output-register state encoding and a width helper.
package fir_out_stream_pkg;

    localparam int FIR_SAMPLE_W  = 16;
    localparam int FIR_OUT_DEPTH = 32;

    typedef struct packed {
        logic [FIR_SAMPLE_W-1:0] data;
        logic                    last;
    } fir_entry_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    // Width of a counter covering FIFO entries plus the output register.
    function automatic int fir_level_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/fir_out_stream_if.sv
// Sample stream in from the FIR datapath and valid/ready stream out.
// master = the side driving samples and out_ready, slave = the buffer.
interface fir_out_stream_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fir_out_stream_fifo.sv
// Synchronous circular-buffer FIFO. The read port is registered and only
// advances on pop, so rd_data doubles as the stream output register.
module fir_out_stream_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rd_data = rd_data_reg;

    // A write into a full buffer is allowed when the head leaves in the same cycle.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (wr_en && !rd_en) begin
            count_next = count_reg + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                    rd_data_reg <= mem[rd_ptr_reg];
                end
            end
        end
    end

endmodule

// File: rtl/fir_out_stream.sv
// Output buffer between the FIR datapath and a registered valid/ready stream,
// with per-beat credit return, flush, sticky overflow and packet counting.
module fir_out_stream
    import fir_out_stream_pkg::*;
#(
    parameter int DATA_W   = FIR_SAMPLE_W,
    parameter int DEPTH    = FIR_OUT_DEPTH,
    parameter int HEADROOM = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fir_out_stream_if.slave          bus,
    input  logic                     flush,
    output logic                     credit,
    output logic [$clog2(DEPTH)+1:0] level,
    output logic [CNT_W-1:0]         pkt_count,
    output logic                     overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(DEPTH) + 2;

    out_state_t        state_reg;
    out_state_t        state_next;
    logic              out_valid;
    logic              load;
    logic              xfer;
    logic [DATA_W:0]   fifo_wr;
    logic [DATA_W:0]   fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              credit_reg;
    logic [CNT_W-1:0]  pkt_count_reg;
    logic              overflow_reg;
    logic              in_ready_reg;

    assign fifo_wr = {bus.in_data, bus.in_last};

    fir_out_stream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (bus.in_valid),
        .wr_data    (fifo_wr),
        .pop        (load),
        .rd_data    (fifo_rd),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (count_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (!fifo_empty) state_next = ST_HOLD;
                ST_HOLD:  if (bus.out_ready && fifo_empty) state_next = ST_EMPTY;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Loading the output register is the FIFO pop; back-to-back when the sink accepts.
    always_comb begin
        out_valid = (state_reg == ST_HOLD);
        load      = !flush && !fifo_empty && (!out_valid || bus.out_ready);
        xfer      = !flush && out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_reg    <= 1'b0;
            pkt_count_reg <= '0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            credit_reg   <= xfer;
            in_ready_reg <= (DEPTH - int'(count_next)) > HEADROOM;
            if (xfer && fifo_rd[0]) begin
                pkt_count_reg <= pkt_count_reg + 1'b1;
            end
            if (flush) begin
                overflow_reg <= 1'b0;
            end else if (bus.in_valid && fifo_full && !load) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = fifo_rd[DATA_W:1];
    assign bus.out_last  = fifo_rd[0];
    assign bus.in_ready  = in_ready_reg;
    assign credit        = credit_reg;
    assign pkt_count     = pkt_count_reg;
    assign overflow      = overflow_reg;
    assign level         = LW'(fifo_count) + LW'(out_valid);

endmodule
